// File: rtl/stack_pkg.sv
// Shared widths for the stack buffer: address, character ID and coordinate sizes.
package stack_pkg;

    localparam int STACK_ADDR_WIDTH = 8;
    localparam int CHAR_ID_WIDTH    = 8;
    localparam int X_WIDTH          = 9;
    localparam int Y_WIDTH          = 9;
    localparam int STACK_DEPTH      = 2 ** STACK_ADDR_WIDTH;

endpackage

// File: rtl/stack_mem_valid_bits.sv
// Per-entry valid flags for the stack storage: cleared asynchronously on reset,
// set when an entry is written, read combinationally by index.
module stack_mem_valid_bits
    import stack_pkg::*;
#(
    parameter int ADDR_WIDTH = STACK_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_address,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] valid_q;

    // Flags only ever go from 0 to 1; reset is the sole way to clear them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[set_address] <= 1'b1;
        end
    end

    assign read_valid = valid_q[read_address];

endmodule

// File: rtl/stack_mem_store.sv
// Stack buffer storage: synchronous write port, registered read port with
// write-first bypass; valid flags hide stale RAM contents after reset.
module stack_mem_store
    import stack_pkg::*;
#(
    parameter int ADDR_WIDTH = STACK_ADDR_WIDTH,
    parameter int DATA_WIDTH = CHAR_ID_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] in_address,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] out_address,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  entry_valid;
    logic                  bypass;

    stack_mem_valid_bits #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_valid_bits (
        .clock       (clock),
        .reset_n     (reset_n),
        .set_en      (we),
        .set_address (in_address),
        .read_address(out_address),
        .read_valid  (entry_valid)
    );

    // RAM body has no reset so it can map onto distributed or block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[in_address] <= in_data;
        end
    end

    assign bypass = we && (in_address == out_address);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (bypass) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else begin
            out_data  <= entry_valid ? mem[out_address] : '0;
            out_valid <= entry_valid;
        end
    end

endmodule

// File: tb/tb_stack_mem_store.sv
// Self-checking bench for stack_mem_store: directed scenarios plus random traffic
// compared every cycle against a write-first array model.
module tb_stack_mem_store;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       we = 1'b0;
    logic [7:0] in_address = '0;
    logic [7:0] in_data = '0;
    logic [7:0] out_address = '0;
    logic [7:0] out_data;
    logic       out_valid;

    logic [7:0] model_mem [256];
    bit   [255:0] model_written = '0;
    logic [7:0] exp_data = '0;
    logic       exp_valid = 1'b0;

    bit         check_en = 1'b0;
    int         lit_seq = 0;
    int         lit_seen = 0;
    string      lit_name = "";
    logic [7:0] lit_data = '0;
    logic       lit_valid = 1'b0;

    int total = 0;
    int bad = 0;

    stack_mem_store dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .we         (we),
        .in_address (in_address),
        .in_data    (in_data),
        .out_address(out_address),
        .out_data   (out_data),
        .out_valid  (out_valid)
    );

    always #5 clock = ~clock;

    // Model and hand-computed expectations are both checked on the falling edge.
    always @(negedge clock) begin
        if (check_en) begin
            total++;
            if (out_data !== exp_data || out_valid !== exp_valid) begin
                bad++;
                $display("[TB] FAIL model t=%0t addr=%02h got data=%02h valid=%b want data=%02h valid=%b",
                         $time, out_address, out_data, out_valid, exp_data, exp_valid);
            end
            if (lit_seq != lit_seen) begin
                lit_seen = lit_seq;
                total++;
                if (out_data !== lit_data || out_valid !== lit_valid) begin
                    bad++;
                    $display("[TB] FAIL %s got data=%02h valid=%b want data=%02h valid=%b",
                             lit_name, out_data, out_valid, lit_data, lit_valid);
                end
                total++;
                if (exp_data !== lit_data || exp_valid !== lit_valid) begin
                    bad++;
                    $display("[TB] FAIL %s_model got data=%02h valid=%b want data=%02h valid=%b",
                             lit_name, exp_data, exp_valid, lit_data, lit_valid);
                end
            end
        end
    end

    // Drives one cycle, then updates the model with write-first semantics.
    task automatic applyStimulus(input logic w, input logic [7:0] ia, input logic [7:0] id,
                                 input logic [7:0] oa);
        we          = w;
        in_address  = ia;
        in_data     = id;
        out_address = oa;
        @(posedge clock);
        #1;
        if (w) begin
            model_mem[ia]     = id;
            model_written[ia] = 1'b1;
        end
        exp_valid = model_written[oa];
        exp_data  = model_written[oa] ? model_mem[oa] : 8'h00;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] d, input logic v);
        lit_name  = name;
        lit_data  = d;
        lit_valid = v;
        lit_seq++;
    endtask

    // Pulls reset mid-cycle while a write is pending; outputs must clear before any edge.
    task automatic doReset(input logic [7:0] ia, input logic [7:0] id);
        we         = 1'b1;
        in_address = ia;
        in_data    = id;
        #2;
        reset_n       = 1'b0;
        model_written = '0;
        exp_data      = 8'h00;
        exp_valid     = 1'b0;
        checkOutput("async_reset", 8'h00, 1'b0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ia;
        logic [7:0] oa;
        #2;
        reset_n  = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_state", 8'h00, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        applyStimulus(1'b0, 8'h00, 8'h00, 8'h05);
        checkOutput("unwritten_05", 8'h00, 1'b0);

        applyStimulus(1'b1, 8'h00, 8'h3C, 8'h05);
        applyStimulus(1'b1, 8'hFF, 8'hA7, 8'h05);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'hFF);
        checkOutput("read_ff", 8'hA7, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("read_00", 8'h3C, 1'b1);

        applyStimulus(1'b1, 8'h10, 8'h11, 8'h00);
        applyStimulus(1'b1, 8'h10, 8'h5A, 8'h10);
        checkOutput("bypass_10", 8'h5A, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h10);
        checkOutput("after_bypass_10", 8'h5A, 1'b1);

        applyStimulus(1'b1, 8'h20, 8'h77, 8'h00);
        applyStimulus(1'b1, 8'h21, 8'h88, 8'h20);
        checkOutput("diff_addr_old", 8'h77, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h21);
        checkOutput("diff_addr_new", 8'h88, 1'b1);

        applyStimulus(1'b1, 8'h7E, 8'h12, 8'h00);
        applyStimulus(1'b1, 8'h7E, 8'h34, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h7E);
        checkOutput("overwrite_7e", 8'h34, 1'b1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(i), 8'(i + 1), 8'h00);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h03);
        checkOutput("prefill_03", 8'h04, 1'b1);
        doReset(8'h40, 8'hEE);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("post_reset_00", 8'h00, 1'b0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 8'(i));
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h40);
        checkOutput("reset_edge_write_dropped", 8'h00, 1'b0);

        // Narrow address window so reads, bypasses and overwrites collide often.
        for (int i = 0; i < 1500; i++) begin
            ia = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            oa = ($urandom_range(0, 2) == 0) ? ia : 8'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), ia, 8'($urandom), oa);
            if (i == 700) begin
                doReset(8'($urandom_range(0, 15)), 8'($urandom));
            end
        end

        @(negedge clock);
        #1;
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_mem_store.md
Name: stack_mem_store

Overview:
- Storage array behind the stack buffer: one synchronous write port, one registered read port.
- The stack controller owns the pointer/size logic and drives both addresses (push writes at in_address, pop reads at out_address).
- Holds 2^ADDR_WIDTH words of DATA_WIDTH bits (character IDs by default).
- A per-entry valid bit hides stale contents after reset, so the RAM body itself needs no clearing.

Parameters:
- ADDR_WIDTH, 8, address width; depth = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 8, word width (matches character ID width).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable for the write port.
- in_address  input  ADDR_WIDTH  write address.
- in_data  input  DATA_WIDTH  write data.
- out_address  input  ADDR_WIDTH  read address, sampled every cycle.
- out_data  output  DATA_WIDTH  registered read data.
- out_valid  output  1  registered; 1 when out_data comes from a written entry.

Interface rule: one clock; reset is asynchronous and active-low (clock port "clock", reset port "reset_n").

Behaviour:
- Reset (reset_n=0, asynchronous): out_data=0, out_valid=0, all 2^ADDR_WIDTH valid bits cleared immediately.
  - RAM words are not cleared; their contents are don't-care.
  - While reset_n=0, writes are ignored and the outputs hold 0.
- Release: first active edge is the first rising clock with reset_n=1.
- Write: rising edge with we=1 sets mem[in_address]<=in_data and valid[in_address]<=1. With we=0 nothing changes.
- Read latency is 1 cycle. Every rising edge (out of reset):
  - out_data<=mem[out_address] if valid[out_address], else 0.
  - out_valid<=valid[out_address].
- Read-during-write, same address (we=1 and in_address==out_address): write-first bypass, out_data<=in_data, out_valid<=1.
- Read-during-write, different addresses: independent; the read returns old contents.
- Overwriting an address replaces the data; the valid bit stays 1.
- There is no invalidate port; valid bits clear only on reset.
- Addresses cover the full range 0..2^ADDR_WIDTH-1, so there is no out-of-range case and no wrap logic inside this block.
- The stack controller uses at most 2^ADDR_WIDTH-1 entries. This block does not enforce that limit and has no full/empty flags.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- The valid array must be flops (async clear). The data array may infer distributed or block RAM, as long as 1-cycle read latency and the bypass are preserved.

Decomposition:
- Shared package stack_pkg:
  - Default widths STACK_ADDR_WIDTH=8, CHAR_ID_WIDTH=8, X_WIDTH=9, Y_WIDTH=9.
  - Derived constant STACK_DEPTH=2^STACK_ADDR_WIDTH.
- One sub-module, stack_mem_valid_bits: async-clear valid-flag array with set-on-write and indexed read. The data array stays inline.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> out_data=0, out_valid=0 without waiting for a clock; after release, read address 0x05 -> out_valid=0, out_data=0x00.
- Write/read: write 0x3C at 0x00, then 0xA7 at 0xFF; set out_address=0xFF -> next edge out_data=0xA7, out_valid=1; set out_address=0x00 -> out_data=0x3C.
- Bypass: we=1, in_address=out_address=0x10, in_data=0x5A (previously 0x11) -> next edge out_data=0x5A, out_valid=1.
- Different-address read during write: 0x20 holds 0x77; write 0x88 to 0x21 while reading 0x20 -> out_data=0x77; reading 0x21 next cycle -> 0x88.
- Reset mid-operation: fill 0x00..0x03 with 0x01..0x04, pulse reset_n low during a write -> read 0x00..0x03 returns out_valid=0, out_data=0; write on the reset edge is not retained.
- Overwrite: write 0x12 then 0x34 to 0x7E -> read returns 0x34, out_valid=1.
